serial_loader: RTL and testbench

Byte-stream boot loader that sits directly downstream of the UART receiver. It consumes one-cycle byte strobes and assembles a length-prefixed, checksummed image into 32-bit big-endian words. Each word is written to a word-addressed memory port through a request/acknowledge handshake. It reports completion or a protocol error so the CPU reset release logic can start execution from the loaded image.

---
 rtl/serial_loader.sv | 105 ++++++++++
 tb/tb_serial_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_loader.sv
// serial_loader: assembles a length-prefixed, XOR-checksummed byte stream into big-endian words and writes them to memory
//   clk, rst          clock, asynchronous active-high reset
//   rx_rd, rx_data    one-cycle byte strobe and byte from the UART receiver
//   start             re-arms the loader from DONE or ERR
//   mem_addr/wdata/we word write request, held until mem_ack
//   busy, done, err   frame in progress / loaded and verified / checksum mismatch or overrun
module serial_loader #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rd,
    input  logic [7:0]        rx_data,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {HDR, DATA, WRITE, CSUM, DONE, ERR} state_t;
    state_t            state_q;
    logic [31:0]       count_q;
    logic [31:0]       word_q;
    logic [7:0]        csum_q;
    logic [1:0]        idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HDR;
            count_q <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                HDR: if (rx_rd) begin
                    count_q <= {count_q[23:0], rx_data};
                    idx_q   <= idx_q + 2'd1;
                    busy_q  <= 1'b1;
                    if (idx_q == 2'd3)
                        state_q <= ({count_q[23:0], rx_data} == 32'd0) ? CSUM : DATA;
                end
                DATA: if (rx_rd) begin
                    word_q <= {word_q[23:0], rx_data};
                    csum_q <= csum_q ^ rx_data;
                    idx_q  <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q <= WRITE;
                        we_q    <= 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        we_q    <= 1'b0;
                        addr_q  <= addr_q + ADDR_W'(1);
                        count_q <= count_q - 32'd1;
                    end
                    // a byte arriving while a write is pending is lost: overrun
                    if (rx_rd) begin
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else if (mem_ack) begin
                        state_q <= (count_q == 32'd1) ? CSUM : DATA;
                    end
                end
                CSUM: if (rx_rd) begin
                    busy_q  <= 1'b0;
                    done_q  <= rx_data == csum_q;
                    err_q   <= rx_data != csum_q;
                    state_q <= (rx_data == csum_q) ? DONE : ERR;
                end
                default: if (start) begin
                    state_q <= HDR;
                    count_q <= '0;
                    csum_q  <= '0;
                    idx_q   <= '0;
                    addr_q  <= BASE_ADDR;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign mem_we    = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: table-driven frames plus overrun and mid-frame reset sequences for serial_loader
module tb_serial_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rd = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        start = 1'b0;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    logic        busy, done, err;
    logic        ack_en = 1'b1;
    int          ack_dly = 0;
    int          wlen = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] wa[$];
    logic [31:0] wd[$];
    int          wl[$];
    bit          ws[$];
    logic [15:0] a0;
    logic [31:0] d0;
    bit          st;

    serial_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut (
        .clk(clk), .rst(rst), .rx_rd(rx_rd), .rx_data(rx_data), .start(start),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // memory model: acknowledges after ack_dly waiting cycles, logs each accepted write
    assign mem_ack = ack_en && mem_we && (wlen == ack_dly);

    always @(posedge clk) begin
        if (mem_we) begin
            if (wlen == 0) begin
                a0 = mem_addr;
                d0 = mem_wdata;
                st = 1'b1;
            end else if (mem_addr !== a0 || mem_wdata !== d0) begin
                st = 1'b0;
            end
            if (mem_ack) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
                wl.push_back(wlen + 1);
                ws.push_back(st);
                wlen <= 0;
            end else begin
                wlen <= wlen + 1;
            end
        end else begin
            wlen <= 0;
        end
    end

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  cs;
        int          dly;
        logic        exp_done;
        logic        exp_err;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_rd = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wl.delete();
        ws.delete();
    endtask

    task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1, input logic [7:0] cs);
        logic [31:0] hdr;
        logic [31:0] w;
        hdr = n;
        for (int k = 0; k < 4; k++) begin
            send_byte(hdr[31-8*k -: 8]);
            if (k == 0) chk("busy_rise", busy, 1);
        end
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
            chk("we_rise", mem_we, 1);
            for (int b = 0; b < 100 && mem_we; b++) @(negedge clk);
            chk("we_timeout", mem_we, 0);
        end
        send_byte(cs);
    endtask

    task automatic check_writes(input int n, input logic [31:0] w0, input logic [31:0] w1, input int dly);
        chk("n_writes", wa.size(), n);
        for (int j = 0; j < n; j++) begin
            chk("wr_addr", (j < wa.size()) ? 32'(wa[j]) : 32'hxxxxxxxx, j);
            chk("wr_data", (j < wd.size()) ? wd[j] : 32'hxxxxxxxx, (j == 0) ? w0 : w1);
            chk("we_len", (j < wl.size()) ? wl[j] : -1, dly + 1);
            chk("wr_stable", (j < ws.size()) ? 32'(ws[j]) : 32'hx, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{n: 1, w0: 32'hDEADBEEF, w1: 32'h0, cs: 8'h22, dly: 0, exp_done: 1'b1, exp_err: 1'b0};
        tbl[1] = '{n: 2, w0: 32'h01020304, w1: 32'hA0B0C0D0, cs: 8'h04, dly: 5, exp_done: 1'b1, exp_err: 1'b0};
        tbl[2] = '{n: 0, w0: 32'h0, w1: 32'h0, cs: 8'h00, dly: 0, exp_done: 1'b1, exp_err: 1'b0};
        tbl[3] = '{n: 1, w0: 32'hDEADBEEF, w1: 32'h0, cs: 8'h23, dly: 0, exp_done: 1'b0, exp_err: 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_we", mem_we, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (i > 0) pulse_start();
            clear_log();
            ack_dly = tbl[i].dly;
            chk("arm_busy", busy, 0);
            chk("arm_done", done, 0);
            chk("arm_err", err, 0);
            chk("arm_addr", mem_addr, 0);
            send_frame(tbl[i].n, tbl[i].w0, tbl[i].w1, tbl[i].cs);
            chk("end_done", done, tbl[i].exp_done);
            chk("end_err", err, tbl[i].exp_err);
            chk("end_busy", busy, 0);
            check_writes(tbl[i].n, tbl[i].w0, tbl[i].w1, tbl[i].dly);
        end

        // bytes after ERR are ignored; start outside DONE/ERR checked implicitly below
        for (int k = 0; k < 5; k++) send_byte(8'h11);
        chk("ign_err", err, 1);
        chk("ign_done", done, 0);
        chk("ign_busy", busy, 0);
        chk("ign_writes", wa.size(), 1);
        chk("ign_we", mem_we, 0);

        // overrun: write held unacknowledged while a byte arrives
        pulse_start();
        clear_log();
        ack_en = 1'b0;
        ack_dly = 0;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        chk("ovr_we_hi", mem_we, 1);
        chk("ovr_wdata", mem_wdata, 32'h12345678);
        send_byte(8'h9A);
        chk("ovr_err", err, 1);
        chk("ovr_we_lo", mem_we, 0);
        chk("ovr_busy", busy, 0);
        chk("ovr_done", done, 0);
        chk("ovr_writes", wa.size(), 0);
        ack_en = 1'b1;
        pulse_start();
        chk("ovr_addr_rst", mem_addr, 0);
        send_frame(1, 32'hDEADBEEF, 32'h0, 8'h22);
        chk("ovr_rec_done", done, 1);
        chk("ovr_rec_err", err, 0);
        check_writes(1, 32'hDEADBEEF, 32'h0, 0);

        // start while busy in HDR must be ignored, then async reset mid-frame
        pulse_start();
        clear_log();
        ack_dly = 5;
        send_byte(8'h00); send_byte(8'h00);
        pulse_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
        chk("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_nowrite", wa.size(), 0);
        send_frame(2, 32'h01020304, 32'hA0B0C0D0, 8'h04);
        chk("arst_done2", done, 1);
        chk("arst_err2", err, 0);
        check_writes(2, 32'h01020304, 32'hA0B0C0D0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
